// File: rtl/alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_operand_sequencer
//  Purpose  : Collects signed operands A, B and an opcode from board switches,
//             one item per debounced LOAD press. Presents the completed set,
//             held stable, to downstream ALU units with a valid/ack handshake.
//             Sequence: WAIT_A -> WAIT_B -> WAIT_OP -> READY.
//  Ports    : clk            system clock (rising edge)
//             rst            asynchronous active-high reset
//             sw_data        operand switches [WIDTH-1:0]
//             sw_op          opcode switches [OP_W-1:0]
//             btn_load       raw LOAD button (asynchronous)
//             btn_clear      raw CLEAR button (asynchronous)
//             result_ack     downstream consumed the operand set (level)
//             A, B, OP       captured operands / opcode
//             operands_valid operand set complete and stable (registered)
//             stage          FSM state for LEDs (00 A, 01 B, 10 OP, 11 READY)
//  Revision : 1.0  initial release
// ============================================================================
module alu_operand_sequencer #(
    parameter int WIDTH       = 6,
    parameter int OP_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_data,
    input  logic [OP_W-1:0]  sw_op,
    input  logic             btn_load,
    input  logic             btn_clear,
    input  logic             result_ack,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [OP_W-1:0]  OP,
    output logic             operands_valid,
    output logic [1:0]       stage
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_DB_MAX = CNT_W'(DB_CYCLES);

    typedef enum logic [1:0] {
        S_WAIT_A  = 2'b00,
        S_WAIT_B  = 2'b01,
        S_WAIT_OP = 2'b10,
        S_READY   = 2'b11
    } state_t;

    // index 0 = load, index 1 = clear
    logic [1:0] w_btn_raw;
    logic [1:0] w_press;

    assign w_btn_raw = {btn_clear, btn_load};

    // ------------------------------------------------------------------
    // Button conditioning: synchronizer + saturating debounce counter.
    // The press pulse is decoded combinationally from the counter value
    // one below saturation, so it is consumed on the very edge the
    // counter saturates. Saturation then blocks further pulses until the
    // synced level drops and clears the counter.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic [SYNC_STAGES-1:0] r_sync;
        logic [CNT_W-1:0]       r_cnt;
        logic                   w_level;

        assign w_level = r_sync[SYNC_STAGES-1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync <= '0;
                r_cnt  <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_btn_raw[gi]};
                if (!w_level) begin
                    r_cnt <= '0;
                end else if (r_cnt != c_DB_MAX) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_press[gi] = w_level && (r_cnt == (c_DB_MAX - 1'b1));
    end

    logic w_load;
    logic w_clr;

    assign w_load = w_press[0];
    assign w_clr  = w_press[1];

    // ------------------------------------------------------------------
    // Sequence FSM
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_WAIT_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_clr) begin
            // clear wins over a coincident load pulse or ack
            w_state_next = S_WAIT_A;
        end else begin
            case (r_state)
                S_WAIT_A:  if (w_load)     w_state_next = S_WAIT_B;
                S_WAIT_B:  if (w_load)     w_state_next = S_WAIT_OP;
                S_WAIT_OP: if (w_load)     w_state_next = S_READY;
                S_READY:   if (result_ack) w_state_next = S_WAIT_A;
                default:                   w_state_next = S_WAIT_A;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Operand capture. Values persist after the ack so the ALU result
    // stays displayable until the next sequence overwrites them.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [OP_W-1:0]  r_op;
    logic             r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= (w_state_next == S_READY);
            if (w_clr) begin
                r_a  <= '0;
                r_b  <= '0;
                r_op <= '0;
            end else if (w_load) begin
                case (r_state)
                    S_WAIT_A:  r_a  <= sw_data;
                    S_WAIT_B:  r_b  <= sw_data;
                    S_WAIT_OP: r_op <= sw_op;
                    default:   ;
                endcase
            end
        end
    end

    assign A              = r_a;
    assign B              = r_b;
    assign OP             = r_op;
    assign operands_valid = r_valid;
    assign stage          = r_state;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_operand_sequencer
//  Purpose  : Self-checking bench for alu_operand_sequencer: table-driven
//             operand sequences plus directed multi-cycle corner cases
//             (latency, bounce, clear priority, async reset, held ack).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_operand_sequencer;

    localparam int K_LOAD  = 0;
    localparam int K_ACK   = 1;
    localparam int K_CLEAR = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] sw_data;
    logic [1:0] sw_op;
    logic       btn_load;
    logic       btn_clear;
    logic       result_ack;
    logic [5:0] A;
    logic [5:0] B;
    logic [1:0] OP;
    logic       operands_valid;
    logic [1:0] stage;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_operand_sequencer #(
        .WIDTH      (6),
        .OP_W       (2),
        .SYNC_STAGES(2),
        .DB_CYCLES  (4)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .sw_data       (sw_data),
        .sw_op         (sw_op),
        .btn_load      (btn_load),
        .btn_clear     (btn_clear),
        .result_ack    (result_ack),
        .A             (A),
        .B             (B),
        .OP            (OP),
        .operands_valid(operands_valid),
        .stage         (stage)
    );

    typedef struct {
        int         kind;
        logic [5:0] data;
        logic [1:0] op;
        logic [5:0] ea;
        logic [5:0] eb;
        logic [1:0] eop;
        logic       ev;
        logic [1:0] est;
    } vec_t;

    vec_t vecs[10];

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [5:0] ea, input logic [5:0] eb,
                             input logic [1:0] eop, input logic ev, input logic [1:0] est);
        check({tag, ".A"},     32'(A),              32'(ea));
        check({tag, ".B"},     32'(B),              32'(eb));
        check({tag, ".OP"},    32'(OP),             32'(eop));
        check({tag, ".valid"}, 32'(operands_valid), 32'(ev));
        check({tag, ".stage"}, 32'(stage),          32'(est));
    endtask

    // Raise LOAD with given switches; stage must be unchanged 5 edges later
    // and updated on the 6th (edge index 5), then release and let it settle.
    task automatic press_timed(input string tag, input logic [5:0] d, input logic [1:0] o,
                               input logic [1:0] st_before, input logic [1:0] st_after);
        sw_data  = d;
        sw_op    = o;
        btn_load = 1'b1;
        tick(5);
        check({tag, ".stage_pre"}, 32'(stage), 32'(st_before));
        tick(1);
        check({tag, ".stage_post"}, 32'(stage), 32'(st_after));
        btn_load = 1'b0;
        tick(4);
    endtask

    task automatic press_clear();
        btn_clear = 1'b1;
        tick(6);
        btn_clear = 1'b0;
        tick(4);
    endtask

    initial begin
        logic [1:0] prev_st;

        vecs[0] = '{K_LOAD,  6'b111101, 2'b00, 6'b111101, 6'b000000, 2'b00, 1'b0, 2'b01};
        vecs[1] = '{K_LOAD,  6'b000101, 2'b00, 6'b111101, 6'b000101, 2'b00, 1'b0, 2'b10};
        vecs[2] = '{K_LOAD,  6'b000000, 2'b10, 6'b111101, 6'b000101, 2'b10, 1'b1, 2'b11};
        vecs[3] = '{K_LOAD,  6'b010101, 2'b01, 6'b111101, 6'b000101, 2'b10, 1'b1, 2'b11};
        vecs[4] = '{K_LOAD,  6'b101010, 2'b11, 6'b111101, 6'b000101, 2'b10, 1'b1, 2'b11};
        vecs[5] = '{K_ACK,   6'b000000, 2'b00, 6'b111101, 6'b000101, 2'b10, 1'b0, 2'b00};
        vecs[6] = '{K_LOAD,  6'b100000, 2'b00, 6'b100000, 6'b000101, 2'b10, 1'b0, 2'b01};
        vecs[7] = '{K_LOAD,  6'b011111, 2'b00, 6'b100000, 6'b011111, 2'b10, 1'b0, 2'b10};
        vecs[8] = '{K_LOAD,  6'b000000, 2'b01, 6'b100000, 6'b011111, 2'b01, 1'b1, 2'b11};
        vecs[9] = '{K_CLEAR, 6'b000000, 2'b00, 6'b000000, 6'b000000, 2'b00, 1'b0, 2'b00};

        rst        = 1'b1;
        sw_data    = '0;
        sw_op      = '0;
        btn_load   = 1'b0;
        btn_clear  = 1'b0;
        result_ack = 1'b0;
        #1;
        check_all("reset", 6'd0, 6'd0, 2'd0, 1'b0, 2'b00);
        tick(3);
        rst = 1'b0;
        tick(3);
        check_all("post_reset", 6'd0, 6'd0, 2'd0, 1'b0, 2'b00);

        // ---------------- table-driven sequences ----------------
        prev_st = 2'b00;
        for (int i = 0; i < 10; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            case (vecs[i].kind)
                K_LOAD:  press_timed(tag, vecs[i].data, vecs[i].op, prev_st, vecs[i].est);
                K_ACK: begin
                    result_ack = 1'b1;
                    tick(1);
                    result_ack = 1'b0;
                    tick(2);
                end
                default: press_clear();
            endcase
            check_all(tag, vecs[i].ea, vecs[i].eb, vecs[i].eop, vecs[i].ev, vecs[i].est);
            prev_st = vecs[i].est;
        end

        // ---------------- bounce: 2 high / 1 low x5, then settle ----------------
        sw_data = 6'b000111;
        for (int i = 0; i < 5; i++) begin
            btn_load = 1'b1;
            tick(2);
            btn_load = 1'b0;
            tick(1);
        end
        check("bounce.no_pulse", 32'(stage), 32'(2'b00));
        btn_load = 1'b1;
        tick(10);
        check("bounce.captured", 32'(A), 32'(6'b000111));
        tick(10);
        check("bounce.one_pulse", 32'(stage), 32'(2'b01));
        btn_load = 1'b0;
        tick(4);

        // ---------------- clear priority in WAIT_OP ----------------
        press_timed("cp_b", 6'b001001, 2'b00, 2'b01, 2'b10);
        sw_op      = 2'b11;
        btn_load   = 1'b1;
        btn_clear  = 1'b1;
        tick(6);
        check_all("clear_prio", 6'd0, 6'd0, 2'd0, 1'b0, 2'b00);
        tick(6);
        check("clear_prio.hold", 32'(stage), 32'(2'b00));
        btn_load  = 1'b0;
        btn_clear = 1'b0;
        tick(4);

        // ---------------- async reset while READY ----------------
        press_timed("ar_a", 6'b110011, 2'b00, 2'b00, 2'b01);
        press_timed("ar_b", 6'b001100, 2'b00, 2'b01, 2'b10);
        press_timed("ar_op", 6'b000000, 2'b11, 2'b10, 2'b11);
        check_all("ar_ready", 6'b110011, 6'b001100, 2'b11, 1'b1, 2'b11);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 6'd0, 6'd0, 2'd0, 1'b0, 2'b00);
        tick(2);
        #3;
        rst = 1'b0;
        tick(2);
        press_timed("ar_after", 6'b101101, 2'b00, 2'b00, 2'b01);
        check("ar_after.A", 32'(A), 32'(6'b101101));
        press_clear();

        // ---------------- result_ack held through the whole sequence ----------------
        result_ack = 1'b1;
        press_timed("ack_a", 6'b100000, 2'b00, 2'b00, 2'b01);
        press_timed("ack_b", 6'b011111, 2'b00, 2'b01, 2'b10);
        sw_op    = 2'b01;
        btn_load = 1'b1;
        tick(6);
        check_all("ack_ready", 6'b100000, 6'b011111, 2'b01, 1'b1, 2'b11);
        tick(1);
        check_all("ack_return", 6'b100000, 6'b011111, 2'b01, 1'b0, 2'b00);
        btn_load = 1'b0;
        tick(10);
        check_all("ack_stay", 6'b100000, 6'b011111, 2'b01, 1'b0, 2'b00);
        result_ack = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
